// File: rtl/sqrt_pkg.sv
// Shared widths, FSM encoding and constants for the root+remainder rebuild path.
package sqrt_pkg;
    localparam int W_ROOT = 8;
    localparam int W_DIN  = 2 * W_ROOT;
    localparam int CNT_W  = $clog2(W_ROOT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W_ROOT - 1);
    localparam logic [7:0]       DROP_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/sq_shift_add.sv
// One combinational shift-add squaring step: adds root<<bit_idx when root[bit_idx] is set.
module sq_shift_add
    import sqrt_pkg::*;
(
    input  logic [W_DIN:0]    acc_in,
    input  logic [W_ROOT-1:0] root,
    input  logic [CNT_W-1:0]  bit_idx,
    output logic [W_DIN:0]    acc_out
);
    logic [W_DIN:0] root_ext;
    logic [W_DIN:0] addend;

    // Carry bit of the W_DIN+1 accumulator is kept so overflow can be flagged later.
    always_comb begin
        root_ext = {{(W_DIN + 1 - W_ROOT){1'b0}}, root};
        if (root[bit_idx]) begin
            addend = root_ext << bit_idx;
        end else begin
            addend = '0;
        end
        acc_out = acc_in + addend;
    end
endmodule

// File: rtl/sqrt_rebuild.sv
// Rebuilds din = root*root + remain over W_ROOT shift-add cycles and flags invalid remainders.
module sqrt_rebuild
    import sqrt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vld,
    input  logic [W_ROOT-1:0] sqrt_in,
    input  logic [W_DIN-1:0]  remain_in,
    output logic              i_rdy,
    output logic              o_vld,
    output logic [W_DIN-1:0]  dout,
    output logic              o_err,
    output logic [7:0]        drop_cnt
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [W_ROOT-1:0] root_q, root_d;
    logic [W_DIN:0]    acc_q, acc_d;
    logic              err_rem_q, err_rem_d;
    logic              o_vld_q, o_vld_d;
    logic [W_DIN-1:0]  dout_q, dout_d;
    logic              o_err_q, o_err_d;
    logic [7:0]        drop_q, drop_d;
    logic [W_DIN:0]    acc_step;

    sq_shift_add u_step (
        .acc_in  (acc_q),
        .root    (root_q),
        .bit_idx (cnt_q),
        .acc_out (acc_step)
    );

    // Next-state, datapath and output-register computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        root_d    = root_q;
        acc_d     = acc_q;
        err_rem_d = err_rem_q;
        o_vld_d   = 1'b0;
        dout_d    = dout_q;
        o_err_d   = o_err_q;
        drop_d    = drop_q;

        if (i_vld && (state_q != ST_IDLE) && (drop_q != DROP_MAX)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_vld) begin
                    root_d    = sqrt_in;
                    acc_d     = {1'b0, remain_in};
                    // A floor-sqrt remainder never exceeds 2*root.
                    err_rem_d = ({1'b0, remain_in} >
                                 {{(W_DIN - W_ROOT){1'b0}}, sqrt_in, 1'b0});
                    cnt_d     = '0;
                    state_d   = ST_MUL;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DONE: begin
                o_vld_d = 1'b1;
                dout_d  = acc_q[W_DIN-1:0];
                o_err_d = err_rem_q | acc_q[W_DIN];
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            root_q    <= '0;
            acc_q     <= '0;
            err_rem_q <= 1'b0;
            o_vld_q   <= 1'b0;
            dout_q    <= '0;
            o_err_q   <= 1'b0;
            drop_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            root_q    <= root_d;
            acc_q     <= acc_d;
            err_rem_q <= err_rem_d;
            o_vld_q   <= o_vld_d;
            dout_q    <= dout_d;
            o_err_q   <= o_err_d;
            drop_q    <= drop_d;
        end
    end

    assign i_rdy    = (state_q == ST_IDLE);
    assign o_vld    = o_vld_q;
    assign dout     = dout_q;
    assign o_err    = o_err_q;
    assign drop_cnt = drop_q;
endmodule

// File: tb/tb_sqrt_rebuild.sv
// Directed and random bench for sqrt_rebuild with a queue-based expected-result scoreboard.
module tb_sqrt_rebuild;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_vld;
    logic [7:0]  sqrt_in;
    logic [15:0] remain_in;
    logic        i_rdy;
    logic        o_vld;
    logic [15:0] dout;
    logic        o_err;
    logic [7:0]  drop_cnt;

    typedef struct packed {
        logic [15:0] d;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    sqrt_rebuild dut (
        .clk       (clk),
        .rst       (rst),
        .i_vld     (i_vld),
        .sqrt_in   (sqrt_in),
        .remain_in (remain_in),
        .i_rdy     (i_rdy),
        .o_vld     (o_vld),
        .dout      (dout),
        .o_err     (o_err),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int root, input int rem);
        exp_t x;
        longint sum;
        sum = longint'(root) * longint'(root) + longint'(rem);
        x.d = sum[15:0];
        x.e = (rem > 2 * root) || (sum > 65535);
        sb.push_back(x);
    endtask

    task automatic pop_check(input string tag);
        exp_t x;
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            x = sb.pop_front();
            check({tag, "_dout"}, 32'(dout), 32'(x.d));
            check({tag, "_err"}, 32'(o_err), 32'(x.e));
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!i_rdy && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", 32'(i_rdy), 32'd1);
    endtask

    // Starts at a negedge; returns at the negedge just after the accepting edge.
    task automatic drive(input int root, input int rem);
        sqrt_in   = 8'(root);
        remain_in = 16'(rem);
        i_vld     = 1'b1;
        push_exp(root, rem);
        @(negedge clk);
        i_vld = 1'b0;
    endtask

    task automatic collect(input string tag, input int start_lat);
        int lat = start_lat;
        while (!o_vld && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd9);
        if (o_vld) begin
            pop_check(tag);
        end else begin
            void'(sb.pop_front());
        end
    endtask

    task automatic run_one(input string tag, input int root, input int rem);
        wait_idle();
        drive(root, rem);
        collect(tag, 0);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (o_vld) pulses++;
        end
        check(tag, 32'(pulses), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepts;
        int root;
        int rem;
        rst = 1'b1;
        i_vld = 1'b0;
        sqrt_in = 8'd0;
        remain_in = 16'd0;
        repeat (20) @(negedge clk);
        check("rst_i_rdy", 32'(i_rdy), 32'd1);
        check("rst_o_vld", 32'(o_vld), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_o_err", 32'(o_err), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_one("r12", 12, 3);
        quiet("hold_no_repulse", 3);
        check("hold_dout", 32'(dout), 32'd147);
        run_one("r255", 255, 510);
        run_one("r181", 181, 7);
        run_one("r10_bad", 10, 21);
        run_one("r0", 0, 0);
        run_one("r0_bad", 0, 5);
        run_one("ovf", 255, 65535);

        // Second pulse three cycles into the run must be dropped.
        wait_idle();
        drive(20, 1);
        @(negedge clk);
        @(negedge clk);
        sqrt_in = 8'd200;
        remain_in = 16'd9;
        i_vld = 1'b1;
        @(negedge clk);
        i_vld = 1'b0;
        collect("drop1", 3);
        check("drop1_cnt", 32'(drop_cnt), 32'd1);
        quiet("drop1_no_second", 12);

        // Continuous i_vld: periodic accepts, the rest counted as drops until saturation.
        accepts = 0;
        sqrt_in = 8'd3;
        remain_in = 16'd0;
        i_vld = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (o_vld) pop_check("b2b");
            if (i_rdy) begin
                push_exp(3, 0);
                accepts++;
            end
            @(negedge clk);
        end
        i_vld = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (o_vld) pop_check("b2b_drain");
            @(negedge clk);
        end
        check("b2b_sb_drained", 32'(sb.size()), 32'd0);
        check("b2b_accepts", 32'(accepts), 32'd30);
        check("drop_sat", 32'(drop_cnt), 32'd255);

        // Reset in the middle of a multiply discards the run.
        wait_idle();
        drive(99, 4);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("midrst_i_rdy", 32'(i_rdy), 32'd1);
        check("midrst_drop", 32'(drop_cnt), 32'd0);
        quiet("midrst_no_vld", 15);

        // Reset together with i_vld: nothing accepted, nothing counted.
        sqrt_in = 8'd50;
        remain_in = 16'd2;
        rst = 1'b1;
        i_vld = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        i_vld = 1'b0;
        check("rstvld_i_rdy", 32'(i_rdy), 32'd1);
        check("rstvld_drop", 32'(drop_cnt), 32'd0);
        quiet("rstvld_no_vld", 12);
        run_one("after_rst", 77, 100);

        for (int i = 0; i < 1000; i++) begin
            root = $urandom_range(0, 255);
            rem  = $urandom_range(0, 2 * root);
            run_one("rand", root, rem);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
